// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and constants for the pipelined control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_R3    = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_PC4 = 2'd1,
        WB_MEM = 2'd2
    } wb_sel_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    typedef struct packed {
        logic    valid;
        logic    reg_wr;
        logic    pc_sel;
        logic    imm_sel;
        logic    jb_sel;
        logic    mem_wr;
        logic    muldiv;
        logic    is_div;
        logic    illegal;
        wb_sel_t wb_sel;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t C_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/pipelined_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_control_unit_if
// Description : ID-side inputs and per-stage control outputs of the unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_control_unit_if;
    logic       id_valid;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       stall_in;
    logic       flush_in;

    logic       ex_valid;
    logic       ex_reg_wr_en;
    logic       ex_pc_rs1_sel;
    logic       ex_imm_rs2_sel;
    logic       ex_jump_branch_sel;
    logic       ex_muldiv;
    logic       ex_illegal;
    logic       mem_valid;
    logic       mem_mem_wr_en;
    logic       mem_reg_wr_en;
    logic       wb_valid;
    logic       wb_reg_wr_en;
    logic [1:0] wb_reg_write_ctrl;
    logic       pipe_stall;

    modport master (
        output id_valid, opcode, funct3, funct7, stall_in, flush_in,
        input  ex_valid, ex_reg_wr_en, ex_pc_rs1_sel, ex_imm_rs2_sel,
               ex_jump_branch_sel, ex_muldiv, ex_illegal,
               mem_valid, mem_mem_wr_en, mem_reg_wr_en,
               wb_valid, wb_reg_wr_en, wb_reg_write_ctrl, pipe_stall
    );

    modport slave (
        input  id_valid, opcode, funct3, funct7, stall_in, flush_in,
        output ex_valid, ex_reg_wr_en, ex_pc_rs1_sel, ex_imm_rs2_sel,
               ex_jump_branch_sel, ex_muldiv, ex_illegal,
               mem_valid, mem_mem_wr_en, mem_reg_wr_en,
               wb_valid, wb_reg_wr_en, wb_reg_write_ctrl, pipe_stall
    );
endinterface
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// Module      : control_decode
// Description : Combinational ID-stage decode into a control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module control_decode
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  wire logic       id_valid,
    input  wire logic [6:0] opcode,
    input  wire logic [2:0] funct3,
    input  wire logic [6:0] funct7,
    output ctrl_bundle_t    ctrl
);

    logic w_unused_funct3;
    assign w_unused_funct3 = ^funct3[1:0];

    always_comb begin
        ctrl = C_BUBBLE;
        if (id_valid) begin
            ctrl.valid = 1'b1;
            case (opcode)
                OP_IMM: begin
                    ctrl.reg_wr  = 1'b1;
                    ctrl.imm_sel = 1'b1;
                end
                OP_R3: begin
                    if (funct7 == FUNCT7_MULDIV) begin
                        if (ENABLE_M) begin
                            ctrl.reg_wr = 1'b1;
                            ctrl.muldiv = 1'b1;
                            ctrl.is_div = funct3[2];
                        end else begin
                            ctrl         = C_BUBBLE;
                            ctrl.illegal = 1'b1;
                        end
                    end else begin
                        ctrl.reg_wr = 1'b1;
                    end
                end
                OP_LD: begin
                    ctrl.reg_wr  = 1'b1;
                    ctrl.imm_sel = 1'b1;
                    ctrl.wb_sel  = WB_MEM;
                end
                OP_ST: begin
                    ctrl.imm_sel = 1'b1;
                    ctrl.mem_wr  = 1'b1;
                end
                OP_BR: begin
                    ctrl.pc_sel  = 1'b1;
                    ctrl.imm_sel = 1'b1;
                    ctrl.jb_sel  = 1'b1;
                end
                OP_LUI: begin
                    ctrl.reg_wr  = 1'b1;
                    ctrl.imm_sel = 1'b1;
                end
                OP_AUIPC: begin
                    ctrl.pc_sel  = 1'b1;
                    ctrl.reg_wr  = 1'b1;
                    ctrl.imm_sel = 1'b1;
                end
                OP_JAL: begin
                    ctrl.pc_sel  = 1'b1;
                    ctrl.reg_wr  = 1'b1;
                    ctrl.imm_sel = 1'b1;
                    ctrl.jb_sel  = 1'b1;
                    ctrl.wb_sel  = WB_PC4;
                end
                OP_JALR: begin
                    ctrl.reg_wr  = 1'b1;
                    ctrl.imm_sel = 1'b1;
                    ctrl.jb_sel  = 1'b1;
                    ctrl.wb_sel  = WB_PC4;
                end
                default: begin
                    // Unknown opcode: a bubble tagged illegal, never any write enable.
                    ctrl         = C_BUBBLE;
                    ctrl.illegal = 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_control_unit
// Description : EX/MEM/WB control registers with a multi-cycle mul/div hold FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    pipelined_control_unit_if.slave bus
);

    localparam logic [3:0] C_MUL_LOAD = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;
    localparam logic [3:0] C_DIV_LOAD = (DIV_LAT > 1) ? 4'(DIV_LAT - 2) : 4'd0;

    ctrl_bundle_t id_ctrl;
    ctrl_bundle_t ex_d,  ex_q;
    ctrl_bundle_t mem_d, mem_q;
    ctrl_bundle_t wb_d,  wb_q;
    md_state_t    state_d, state_q;
    logic [3:0]   cnt_d, cnt_q;

    control_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .id_valid (bus.id_valid),
        .opcode   (bus.opcode),
        .funct3   (bus.funct3),
        .funct7   (bus.funct7),
        .ctrl     (id_ctrl)
    );

    always_comb begin
        ex_d    = ex_q;
        mem_d   = ex_q;
        wb_d    = mem_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush_in) begin
            ex_d    = C_BUBBLE;
            state_d = MD_IDLE;
            cnt_d   = 4'd0;
        end else if (state_q == MD_BUSY) begin
            // EX keeps the mul/div; the final EX cycle is spent back in IDLE.
            mem_d = C_BUBBLE;
            if (cnt_q == 4'd0) begin
                state_d = MD_IDLE;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (bus.stall_in) begin
            ex_d = C_BUBBLE;
        end else begin
            ex_d = id_ctrl;
            if (id_ctrl.muldiv) begin
                if (id_ctrl.is_div && (DIV_LAT > 1)) begin
                    state_d = MD_BUSY;
                    cnt_d   = C_DIV_LOAD;
                end else if (!id_ctrl.is_div && (MUL_LAT > 1)) begin
                    state_d = MD_BUSY;
                    cnt_d   = C_MUL_LOAD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= C_BUBBLE;
            mem_q   <= C_BUBBLE;
            wb_q    <= C_BUBBLE;
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pipe_stall = !reset && !bus.flush_in &&
                            (bus.stall_in || (state_q == MD_BUSY));

    assign bus.ex_valid           = ex_q.valid;
    assign bus.ex_reg_wr_en       = ex_q.reg_wr;
    assign bus.ex_pc_rs1_sel      = ex_q.pc_sel;
    assign bus.ex_imm_rs2_sel     = ex_q.imm_sel;
    assign bus.ex_jump_branch_sel = ex_q.jb_sel;
    assign bus.ex_muldiv          = ex_q.muldiv;
    assign bus.ex_illegal         = ex_q.illegal;
    assign bus.mem_valid          = mem_q.valid;
    assign bus.mem_mem_wr_en      = mem_q.mem_wr;
    assign bus.mem_reg_wr_en      = mem_q.reg_wr;
    assign bus.wb_valid           = wb_q.valid;
    assign bus.wb_reg_wr_en       = wb_q.reg_wr;
    assign bus.wb_reg_write_ctrl  = wb_q.wb_sel;

    logic w_unused_wb;
    assign w_unused_wb = ^{wb_q.pc_sel, wb_q.imm_sel, wb_q.jb_sel, wb_q.mem_wr,
                           wb_q.muldiv, wb_q.is_div, wb_q.illegal};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_control_unit
// Description : Directed self-checking bench for the pipelined control unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_control_unit;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       stall_in;
    logic       flush_in;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipelined_control_unit_if b1 ();
    pipelined_control_unit_if b2 ();
    pipelined_control_unit_if b3 ();

    assign {b1.id_valid, b1.opcode, b1.funct3, b1.funct7, b1.stall_in, b1.flush_in} =
           {id_valid, opcode, funct3, funct7, stall_in, flush_in};
    assign {b2.id_valid, b2.opcode, b2.funct3, b2.funct7, b2.stall_in, b2.flush_in} =
           {id_valid, opcode, funct3, funct7, stall_in, flush_in};
    assign {b3.id_valid, b3.opcode, b3.funct3, b3.funct7, b3.stall_in, b3.flush_in} =
           {id_valid, opcode, funct3, funct7, stall_in, flush_in};

    pipelined_control_unit #(.ENABLE_M(1'b1), .MUL_LAT(2), .DIV_LAT(8))
        u_dut (.clk(clk), .reset(reset), .bus(b1));
    pipelined_control_unit #(.ENABLE_M(1'b0), .MUL_LAT(2), .DIV_LAT(8))
        u_dut_nom (.clk(clk), .reset(reset), .bus(b2));
    pipelined_control_unit #(.ENABLE_M(1'b1), .MUL_LAT(1), .DIV_LAT(2))
        u_dut_lat1 (.clk(clk), .reset(reset), .bus(b3));

    // {valid, reg_wr, pc, imm, jb, muldiv, illegal}
    logic [6:0] ex1;
    // {valid, mem_wr, reg_wr}
    logic [2:0] mem1;
    // {valid, reg_wr, wb_ctrl[1:0]}
    logic [3:0] wb1;
    assign ex1  = {b1.ex_valid, b1.ex_reg_wr_en, b1.ex_pc_rs1_sel, b1.ex_imm_rs2_sel,
                   b1.ex_jump_branch_sel, b1.ex_muldiv, b1.ex_illegal};
    assign mem1 = {b1.mem_valid, b1.mem_mem_wr_en, b1.mem_reg_wr_en};
    assign wb1  = {b1.wb_valid, b1.wb_reg_wr_en, b1.wb_reg_write_ctrl};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic ins(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7);
        id_valid = v;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st, md, st3, md3, first, bub;

        reset = 1'b1; stall_in = 1'b1; flush_in = 1'b1;
        ins(1'b1, OP_IMM, 3'd0, 7'd0);
        #2;
        chk("rst_pipe_stall", b1.pipe_stall, 0);
        tick();
        chk("rst_ex", ex1, 0);
        chk("rst_mem", mem1, 0);
        chk("rst_wb", wb1, 0);

        reset = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
        ins(1'b1, OP_IMM, 3'd0, 7'd0); tick();
        chk("addi_ex", ex1, 7'b1101000);
        ins(1'b1, OP_LD, 3'd2, 7'd0); tick();
        chk("lw_ex", ex1, 7'b1101000);
        chk("addi_mem", mem1, 3'b101);
        ins(1'b1, OP_ST, 3'd2, 7'd0); tick();
        chk("sw_ex", ex1, 7'b1001000);
        chk("lw_mem", mem1, 3'b101);
        chk("addi_wb", wb1, 4'b1100);
        ins(1'b1, OP_JAL, 3'd0, 7'd0); tick();
        chk("jal_ex", ex1, 7'b1111100);
        chk("sw_mem", mem1, 3'b110);
        chk("lw_wb", wb1, 4'b1110);
        ins(1'b1, OP_BR, 3'd0, 7'd0); tick();
        chk("br_ex", ex1, 7'b1011100);
        chk("jal_mem", mem1, 3'b101);
        chk("sw_wb", wb1, 4'b1000);
        ins(1'b1, OP_AUIPC, 3'd0, 7'd0); tick();
        chk("auipc_ex", ex1, 7'b1111000);
        chk("jal_wb", wb1, 4'b1101);
        ins(1'b1, OP_JALR, 3'd0, 7'd0); tick();
        chk("jalr_ex", ex1, 7'b1101100);
        ins(1'b1, OP_LUI, 3'd0, 7'd0); tick();
        chk("lui_ex", ex1, 7'b1101000);
        ins(1'b1, OP_R3, 3'd0, 7'd0); tick();
        chk("add_ex", ex1, 7'b1100000);
        ins(1'b0, OP_IMM, 3'd0, 7'd0); tick();
        chk("idle_ex_bubble", ex1, 0);
        tick(); tick();
        chk("drain_wb", wb1, 0);

        // MUL: MUL_LAT=2 on b1, illegal on b2, single-cycle on b3
        ins(1'b1, OP_R3, 3'b000, FUNCT7_MULDIV); tick();
        ins(1'b0, OP_IMM, 3'd0, 7'd0);
        chk("mul_ex", ex1, 7'b1100010);
        chk("nom_mul_ex", {b2.ex_valid, b2.ex_illegal, b2.ex_reg_wr_en, b2.ex_muldiv}, 4'b0100);
        st = 0; md = 0; st3 = 0; md3 = 0; first = -1;
        for (int i = 0; i < 12; i++) begin
            st  += int'(b1.pipe_stall);
            md  += int'(b1.ex_muldiv);
            st3 += int'(b3.pipe_stall);
            md3 += int'(b3.ex_muldiv);
            if (b1.mem_valid && first < 0) first = i;
            tick();
        end
        chk("mul_stall_cycles", 16'(st), 1);
        chk("mul_ex_cycles", 16'(md), 2);
        chk("mul_mem_arrival", 16'(first), 2);
        chk("lat1_mul_stall_cycles", 16'(st3), 0);
        chk("lat1_mul_ex_cycles", 16'(md3), 1);

        // DIV: 8 EX cycles, 7 stall cycles, stall_in during BUSY is absorbed
        ins(1'b1, OP_R3, 3'b100, FUNCT7_MULDIV); tick();
        ins(1'b0, OP_IMM, 3'd0, 7'd0);
        st = 0; md = 0; first = -1; bub = 0;
        for (int i = 0; i < 14; i++) begin
            stall_in = (i == 2 || i == 3);
            #1;
            st += int'(b1.pipe_stall);
            md += int'(b1.ex_muldiv);
            if (b1.mem_valid && first < 0) first = i;
            if (i >= 1 && i < 8 && !b1.mem_valid) bub++;
            tick();
        end
        stall_in = 1'b0;
        chk("div_stall_cycles", 16'(st), 7);
        chk("div_ex_cycles", 16'(md), 8);
        chk("div_mem_bubbles", 16'(bub), 7);
        chk("div_mem_arrival", 16'(first), 8);

        // DIV aborted by a flush in its third BUSY cycle
        ins(1'b1, OP_R3, 3'b100, FUNCT7_MULDIV); tick();
        ins(1'b0, OP_IMM, 3'd0, 7'd0);
        tick(); tick();
        flush_in = 1'b1;
        #1;
        chk("flush_gates_stall", b1.pipe_stall, 0);
        tick();
        flush_in = 1'b0;
        #1;
        chk("flush_ex_valid", b1.ex_valid, 0);
        chk("flush_fsm_idle", b1.pipe_stall, 0);
        tick(); tick();

        // stall_in and flush_in together, then an unknown opcode
        ins(1'b1, OP_IMM, 3'd0, 7'd0);
        stall_in = 1'b1; flush_in = 1'b1;
        #1;
        chk("stall_flush_pipe_stall", b1.pipe_stall, 0);
        tick();
        stall_in = 1'b0; flush_in = 1'b0;
        chk("stall_flush_ex", ex1, 0);
        ins(1'b1, 7'h7F, 3'd0, 7'd0); tick();
        chk("illegal_ex", ex1, 7'b0000001);
        ins(1'b0, OP_IMM, 3'd0, 7'd0); tick();
        chk("illegal_one_cycle", ex1, 0);
        chk("illegal_mem_no_enables", mem1, 0);

        // Reset in the middle of a DIV
        ins(1'b1, OP_R3, 3'b100, FUNCT7_MULDIV); tick();
        ins(1'b0, OP_IMM, 3'd0, 7'd0);
        tick(); tick();
        reset = 1'b1; stall_in = 1'b1;
        #1;
        chk("rst_mid_div_stall", b1.pipe_stall, 0);
        tick();
        chk("rst_mid_div_ex", ex1, 0);
        chk("rst_mid_div_mem", mem1, 0);
        chk("rst_mid_div_wb", wb1, 0);
        reset = 1'b0; stall_in = 1'b0;
        #1;
        chk("rst_mid_div_fsm_idle", b1.pipe_stall, 0);
        tick();
        chk("rst_mid_div_ex_after", ex1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
